// File: rtl/pio_poll_ctrl.sv
// pio_poll_ctrl: polls an Avalon-MM input PIO and queues timestamped sample changes for the CPU
module pio_poll_ctrl #(
  parameter int DATA_W         = 17,
  parameter int TS_W           = 14,
  parameter int FIFO_DEPTH     = 8,
  parameter int DIV_W          = 16,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WAIT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_W+TS_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] last_q, last_d, smp;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [DIV_W-1:0] period_q, period_d, wcnt_q, wcnt_d, peff;
  logic have_last_q, have_last_d, ovf_q, ovf_d, enable_q, enable_d;
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic cap, empty, full, pop, push_req, push_ok, flush, wr_ctrl;
  logic unused;
  assign unused = ^{pio_readdata[31:DATA_W], s_writedata[31:DIV_W]};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // dropping enable aborts any state; a capture already in progress still lands
  always_comb
    state_d = !enable_q ? IDLE :
              state_q == IDLE ? ISSUE :
              state_q == ISSUE ? CAPTURE :
              state_q == CAPTURE ? (peff == DIV_W'(2) ? ISSUE : WAIT) :
              wcnt_q == '0 ? ISSUE : WAIT;
  always_comb
    pio_address = state_q == ISSUE ? 2'd0 : 2'd3;
  always_comb begin
    cap         = state_q == CAPTURE;
    smp         = pio_readdata[DATA_W-1:0];
    empty       = count_q == '0;
    full        = count_q == CW'(FIFO_DEPTH);
    pop         = s_read && s_address == 2'd0 && !empty;
    flush       = s_write && s_address == 2'd2 && s_writedata[2];
    wr_ctrl     = s_write && s_address == 2'd2;
    push_req    = cap && (!have_last_q || smp != last_q);
    push_ok     = push_req && (!full || pop) && !flush;
    wr_ptr_d    = flush ? '0 : wr_ptr_q + AW'(push_ok);
    rd_ptr_d    = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d     = flush ? '0 : count_q + CW'(push_ok) - CW'(pop);
    ovf_d       = (push_req && full && !pop) ||
                  (ovf_q && !(s_write && s_address == 2'd1 && s_writedata[2]));
    ts_d        = cap ? ts_q + TS_W'(1) : ts_q;
    last_d      = cap ? smp : last_q;
    have_last_d = enable_q && (cap || have_last_q);
    peff        = period_q < DIV_W'(2) ? DIV_W'(2) : period_q;
    wcnt_d      = cap ? peff - DIV_W'(3) : state_q == WAIT ? wcnt_q - DIV_W'(1) : wcnt_q;
    enable_d    = wr_ctrl ? s_writedata[0] : enable_q;
    irq_en_d    = wr_ctrl ? s_writedata[1] : irq_en_q;
    period_d    = s_write && s_address == 2'd3 ? s_writedata[DIV_W-1:0] : period_q;
    irq_d       = irq_en_q && (!empty || ovf_q);
    rdata_d     = !s_read ? rdata_q :
                  s_address == 2'd0 ? (empty ? 32'd0 : 32'({1'b1, mem_q[rd_ptr_q]})) :
                  s_address == 2'd1 ? {20'd0, 4'(count_q), 5'd0, ovf_q, full, empty} :
                  s_address == 2'd2 ? {30'd0, irq_en_q, enable_q} :
                  32'(period_q);
  end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= {ts_q, smp};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      ts_q        <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      wcnt_q      <= '0;
      period_q    <= DIV_W'(DEFAULT_PERIOD);
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      ts_q        <= ts_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      wcnt_q      <= wcnt_d;
      period_q    <= period_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  assign s_readdata = rdata_q;
  assign irq        = irq_q;
endmodule

// File: tb/tb_pio_poll_ctrl.sv
// tb_pio_poll_ctrl: directed test of pio_poll_ctrl against a queue-based poll-schedule model
module tb_pio_poll_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] pio_address, s_address = 2'd0;
  logic [31:0] pio_readdata = 32'd0, s_writedata = 32'd0, s_readdata;
  logic s_read = 1'b0, s_write = 1'b0, irq;
  logic [16:0] pio_val = 17'd0;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  pio_poll_ctrl dut (
    .clk(clk), .reset_n(reset_n), .pio_address(pio_address), .pio_readdata(pio_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .irq(irq)
  );
  always #5 clk = ~clk;
  // input PIO slave: registered readdata, garbage in the upper bits and on other addresses
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pio_readdata <= pio_address == 2'd0 ? {15'h2AAA, pio_val} : 32'hFFFF_FFFF;
  end
  logic [30:0] q[$];
  logic m_en, m_ie, m_have, m_ovf, m_irq, m_issue, m_cap;
  logic [15:0] m_per;
  logic [13:0] m_ts;
  logic [16:0] m_last, m_smp;
  logic [31:0] m_rd;
  int m_next, mc;
  // model: polls are scheduled as absolute cycle numbers, FIFO is a queue
  always @(posedge clk or negedge reset_n) begin : model
    logic [31:0] rv;
    logic pop, push, n_issue, n_cap, irq_n;
    int peff;
    if (!reset_n) begin
      q.delete();
      m_en = 0; m_ie = 0; m_have = 0; m_ovf = 0; m_irq = 0; m_issue = 0; m_cap = 0;
      m_per = 16'd1000; m_ts = 0; m_last = 0; m_smp = 0; m_rd = 0; m_next = -1; mc = 0;
    end else begin
      case (s_address)
        2'd0: rv = q.size() != 0 ? {1'b1, q[0]} : 32'd0;
        2'd1: rv = {20'd0, 4'(q.size()), 5'd0, m_ovf, q.size() == 8, q.size() == 0};
        2'd2: rv = {30'd0, m_ie, m_en};
        default: rv = {16'd0, m_per};
      endcase
      irq_n = m_ie && (q.size() != 0 || m_ovf);
      pop = s_read && s_address == 2'd0 && q.size() != 0;
      push = m_cap && (!m_have || m_smp != m_last);
      peff = m_per < 16'd2 ? 2 : int'(m_per);
      if (pop) void'(q.pop_front());
      if (s_write && s_address == 2'd1 && s_writedata[2]) m_ovf = 0;
      if (push) begin
        if (q.size() < 8) q.push_back({m_ts, m_smp});
        else m_ovf = 1;
      end
      if (s_write && s_address == 2'd2 && s_writedata[2]) q.delete();
      if (m_cap) begin
        m_last = m_smp; m_have = 1; m_ts = m_ts + 14'd1; m_next = mc - 1 + peff;
      end
      if (!m_en) m_have = 0;
      if (m_issue) begin m_smp = pio_val; m_next = -1; end
      n_cap = m_issue && m_en;
      n_issue = m_en && ((m_next < 0 && !m_issue && !m_cap) || m_next == mc + 1);
      if (!m_en) m_next = -1;
      if (s_write && s_address == 2'd2) begin m_en = s_writedata[0]; m_ie = s_writedata[1]; end
      if (s_write && s_address == 2'd3) m_per = s_writedata[15:0];
      if (s_read) m_rd = rv;
      m_irq = irq_n; m_issue = n_issue; m_cap = n_cap; mc++;
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (reset_n) begin
      check("s_readdata", s_readdata, m_rd);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      check("pio_address", {30'd0, pio_address}, m_issue ? 32'd0 : 32'd3);
    end
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); s_write = 1; s_address = a; s_writedata = d;
    @(negedge clk); s_write = 0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); s_read = 1; s_address = a;
    @(negedge clk); s_read = 0; d = s_readdata;
  endtask
  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(nm, d, exp);
  endtask
  task automatic do_reset();
    reset_n = 0; s_read = 0; s_write = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask
  task automatic next_issue(input bit tog);
    int i = 0;
    do begin @(negedge clk); i++; end while (pio_address != 2'd0 && i < 64);
    check("issue_seen", {30'd0, pio_address}, 32'd0);
    if (tog) pio_val ^= 17'd3;
  endtask
  // n polls, then disable during the last ISSUE so exactly n captures complete
  task automatic run_polls(input int n, input bit tog, input int gap);
    int last = 0;
    for (int k = 1; k <= n; k++) begin
      next_issue(tog);
      if (k > 1 && gap > 0) check("issue_gap", 32'(cyc - last), 32'(gap));
      last = cyc;
    end
    s_write = 1; s_address = 2'd2; s_writedata = 32'd0;
    @(negedge clk); s_write = 0;
  endtask
  initial begin
    logic [31:0] d;
    reset_n = 0;
    @(negedge clk);
    check("rst_rdata", s_readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_addr", {30'd0, pio_address}, 32'd3);
    do_reset();
    rd_chk("rst_period", 2'd3, 32'd1000);
    rd_chk("rst_status", 2'd1, 32'h001);
    rd_chk("rst_ctrl", 2'd2, 32'd0);
    pio_val = 17'h1ABCD;
    wr(2'd3, 32'd4); wr(2'd2, 32'd1);
    run_polls(3, 1'b0, 4);
    rd_chk("const_status", 2'd1, 32'h100);
    rd_chk("const_data", 2'd0, 32'h8001ABCD);
    rd_chk("const_status2", 2'd1, 32'h001);
    do_reset();
    pio_val = 17'd2;
    wr(2'd3, 32'd2); wr(2'd2, 32'd1);
    run_polls(5, 1'b1, 2);
    rd_chk("tog_status", 2'd1, 32'h500);
    rd_chk("tog_d0", 2'd0, 32'h80000001);
    rd_chk("tog_d1", 2'd0, 32'h80020002);
    rd_chk("tog_d2", 2'd0, 32'h80040001);
    rd_chk("tog_d3", 2'd0, 32'h80060002);
    rd_chk("tog_d4", 2'd0, 32'h80080001);
    do_reset();
    pio_val = 17'd2;
    wr(2'd3, 32'd2); wr(2'd2, 32'd1);
    run_polls(10, 1'b1, 0);
    rd_chk("ovf_status", 2'd1, 32'h806);
    rd_chk("ovf_head", 2'd0, 32'h80000001);
    wr(2'd1, 32'd4);
    rd_chk("ovf_w1c", 2'd1, 32'h700);
    do_reset();
    pio_val = 17'h55;
    wr(2'd3, 32'd4); wr(2'd2, 32'd3);
    next_issue(1'b0);
    @(negedge clk); check("irq_cap", {31'd0, irq}, 32'd0);
    @(negedge clk); check("irq_push", {31'd0, irq}, 32'd0);
    @(negedge clk); check("irq_rise", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'd2);
    rd_chk("irq_data", 2'd0, 32'h80000055);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk); check("irq_fall", {31'd0, irq}, 32'd0);
    rd_chk("empty_data", 2'd0, 32'd0);
    do_reset();
    pio_val = 17'd2;
    wr(2'd3, 32'd4); wr(2'd2, 32'd1);
    for (int k = 0; k < 9; k++) next_issue(1'b1);
    @(negedge clk); s_read = 1; s_address = 2'd0;
    @(negedge clk); s_read = 0;
    check("pp_data", s_readdata, 32'h80000001);
    s_write = 1; s_address = 2'd2; s_writedata = 32'd0;
    @(negedge clk); s_write = 0;
    rd_chk("pp_status", 2'd1, 32'h802);
    wr(2'd2, 32'd4);
    rd_chk("flush_status", 2'd1, 32'h001);
    rd_chk("flush_ctrl", 2'd2, 32'd0);
    wr(2'd2, 32'd1);
    next_issue(1'b1);
    @(negedge clk); s_write = 1; s_address = 2'd2; s_writedata = 32'd5;
    @(negedge clk); s_writedata = 32'd0;
    @(negedge clk); s_write = 0;
    rd_chk("flush_push", 2'd1, 32'h001);
    do_reset();
    pio_val = 17'd2;
    wr(2'd3, 32'd8); wr(2'd2, 32'd3);
    for (int k = 0; k < 3; k++) next_issue(1'b1);
    rd(2'd2, d);
    check("mid_ctrl", d, 32'd3);
    @(negedge clk); check("mid_irq", {31'd0, irq}, 32'd1);
    @(posedge clk); #2 reset_n = 0;
    #1;
    check("arst_rdata", s_readdata, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    check("arst_addr", {30'd0, pio_address}, 32'd3);
    @(negedge clk); reset_n = 1;
    rd_chk("arst_period", 2'd3, 32'd1000);
    rd_chk("arst_status", 2'd1, 32'h001);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule

// File: doc/pio_poll_ctrl.md
Name: pio_poll_ctrl

Overview:
- Polling controller for the 17-bit Avalon-MM input PIO (`*_regs` style slave: no read strobe, readdata registered, one-cycle latency).
- Periodically issues a read of PIO word 0 and compares the result with the previous sample.
- Pushes changed samples, tagged with a poll-count timestamp, into a small FIFO.
- The CPU drains the FIFO through its own Avalon-MM slave. IRQ is raised while data is pending or an overflow has occurred.

Parameters:
- DATA_W, 17: PIO sample width; DATA_W+TS_W must equal 31.
- TS_W, 14: timestamp (poll counter) width.
- FIFO_DEPTH, 8: entries; power of two.
- DIV_W, 16: PERIOD register width.
- DEFAULT_PERIOD, 1000: PERIOD reset value, in clocks.

Ports:
- clk, input, 1: single clock.
- reset_n, input, 1: asynchronous active-low reset.
- pio_address, output, 2: address to the PIO slave.
- pio_readdata, input, 32: PIO slave readdata.
- s_address, input, 2: CPU register select.
- s_read, input, 1: CPU read strobe.
- s_write, input, 1: CPU write strobe.
- s_writedata, input, 32: CPU write data.
- s_readdata, output, 32: CPU read data, registered, 1-cycle latency.
- irq, output, 1: level interrupt.

Behaviour:
- Reset (async, active-low): FSM=IDLE; pio_address=3; s_readdata=0; irq=0; FIFO empty, pointers 0; overflow=0; enable=0; irq_en=0; PERIOD=DEFAULT_PERIOD; ts=0; have_last=0; last_sample=0.
- Register map:
  - 0 DATA (read pops): {valid, ts[TS_W-1:0], sample[DATA_W-1:0]}. When empty: returns 0 and does not pop.
  - 1 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky; write 1 to bit2 clears), bits[11:8] count.
  - 2 CTRL: bit0 enable, bit1 irq_en. Writing bit2=1 flushes (self-clearing, reads 0).
  - 3 PERIOD: DIV_W bits; effective period Peff = max(PERIOD,2).
- Writes to DATA are ignored. Reads of DATA/STATUS/CTRL/PERIOD return zero-extended fields.
- FSM states: IDLE, ISSUE, CAPTURE, WAIT.
  - IDLE: if enable, go to ISSUE.
  - ISSUE (1 cycle): pio_address=0. Next state is CAPTURE.
  - CAPTURE (1 cycle): latch smp=pio_readdata[DATA_W-1:0]. If !have_last or smp!=last_sample, push {ts,smp}. Then last_sample<=smp, have_last<=1, ts<=ts+1 (wraps at 2^TS_W). If Peff==2, go to ISSUE; else load wait counter with Peff-3 and go to WAIT.
  - WAIT: decrement the counter; at 0, go to ISSUE.
  - Result: ISSUE asserts exactly every Peff clocks.
  - pio_address=3 in every state except ISSUE.
- PERIOD writes take effect at the next counter load.
- Clearing enable: FSM goes to IDLE on the next edge, aborting from any state. A CAPTURE in that same cycle still completes. FIFO, ts and last_sample are retained; have_last is cleared.
- Setting enable from 0: the first ISSUE occurs 1 cycle after the IDLE->ISSUE transition. The first sample is always pushed.
- FIFO rules:
  - Push when full: entry dropped, overflow<=1; last_sample and ts still update.
  - Push and pop in the same cycle: both occur and count is unchanged. When full, a simultaneous pop frees a slot, so no overflow.
  - Flush: pointers and count go to 0. Overflow, ts and last_sample are unchanged. A flush coinciding with a push leaves the FIFO empty (flush wins).
- s_readdata registered: DATA read at edge N presents the FIFO head at N+1; the pop happens at edge N.
- irq = irq_en & (!empty | overflow), registered, so it is 1 cycle after the cause.

Test Plan:
- PERIOD=4, enable; pio_readdata constant 0x1ABCD -> ISSUE every 4 clks; exactly 1 FIFO entry, DATA read = 0x80000000|(0<<17)|0x1ABCD; count then 0.
- PERIOD=2; input toggles 0x00001/0x00002 each poll -> entries with ts 0,1,2,… consecutive; captures 2 clks apart.
- 10 changes with FIFO_DEPTH=8, no reads -> STATUS full=1, overflow=1, count=8; head ts=0; W1C bit2 clears overflow.
- irq_en=1: irq rises 1 clk after the first push; drain all -> irq falls 1 clk after the last pop; empty DATA read returns 0.
- Pop on the same cycle as CAPTURE push with FIFO full -> no overflow, count stays 8. Flush during CAPTURE push -> count 0.
- Assert reset_n low mid-WAIT with 3 entries -> all outputs 0, pio_address=3, PERIOD=1000, FIFO empty immediately (asynchronous).
